fetch_unit: RTL
===============

# fetch_unit

- Instruction fetch stage directly upstream of the control unit. Holds the program counter and reads instruction words from instruction memory over a req/ack handshake.
- Splits each word into opcode, register fields and an optional immediate word, then presents the result to decode over a valid/ready handshake.
- Stops permanently when decode signals halt. Supports PC redirect from the execute stage.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and instruction memory word address
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  ADDR_WIDTH  word address; stable while imem_req high
- imem_ack  in  1  request accepted; imem_rdata valid this cycle
- imem_rdata  in  32  instruction or immediate word
- instr_valid  out  1  decoded instruction available
- instr_ready  in  1  decode accepts the instruction
- opcode  out  8  imem word [31:24]
- rdest  out  4  word [23:20]
- rsrc1  out  4  word [19:16]
- rsrc2  out  4  word [15:12]
- imm  out  32  second word for long-form opcodes, else zero-extended word [15:0]
- instr_pc  out  ADDR_WIDTH  address of the instruction's first word
- halt  in  1  halt from control unit
- halted  out  1  fetch stopped
- branch_en  in  1  redirect request (see Configuration)
- branch_target  in  ADDR_WIDTH  redirect address

## Operation
States:
- **FETCH_WORD**
  - Drive imem_req=1 with imem_addr=pc.
  - On imem_ack, latch the fields and set pc<=pc+1.
  - If opcode[7:5] is 3'b101 or 3'b110 (long form: cpyi, stoa, loda), go to FETCH_IMM. Otherwise go to ISSUE.
- **FETCH_IMM**
  - Drive imem_req=1 with imem_addr=pc.
  - On imem_ack, imm<=imem_rdata, pc<=pc+1, go to ISSUE.
- **ISSUE**
  - Drive instr_valid=1. All instruction outputs are held stable.
  - On instr_valid && instr_ready, go to FETCH_WORD.
- **HALTED**
  - imem_req=0, instr_valid=0, halted=1.
  - Exit only by rst.

Rules:
- PC is word-addressed, increments by 1 and wraps modulo 2^ADDR_WIDTH. Wrap is silent, no error.
- The bus is never abandoned. Once imem_req rises it stays high with a constant imem_addr until imem_ack.
- **halt:**
  - In ISSUE or with no request outstanding, go to HALTED next cycle.
  - With a request outstanding, wait for imem_ack, discard the data, then go to HALTED.
  - Latched: a one-cycle pulse is sufficient.
- **Redirect:**
  - pc<=branch_target.
  - Any buffered instruction is dropped: instr_valid falls the next cycle, even without instr_ready.
  - A partially fetched long-form instruction is dropped.
  - An outstanding request completes with its data discarded.
  - Fetch restarts in FETCH_WORD at the target.
  - A redirect arriving while a discard is pending overwrites the pending target; the last one wins.
- **halt and branch_en in the same cycle:** halt wins and the redirect is ignored.
- **instr_ready while instr_valid=0:** ignored.

## Timing
- **Reset values:** state=FETCH_WORD, pc=RESET_PC, instr_valid=0, all instruction fields 0, instr_pc=0, halted=0.
  - imem_req is forced 0 while rst is high.
  - imem_req rises in the first cycle after rst falls.
- Reset mid-operation aborts everything the same cycle. The bus slave must tolerate a dropped imem_req.
- **Short form:** imem_ack in cycle N -> instr_valid=1 in N+1.
- **Long form:** second imem_ack in cycle M -> instr_valid=1 in M+1.
- **Issue to next fetch:** handshake in cycle K -> imem_req for the next pc in K+1.
- **Peak throughput:** one short instruction per 2 cycles with zero-wait memory. No overlap of fetch and issue.
- **halt observed in cycle H, no outstanding request** -> halted=1 in H+1, imem_req=0 from H+1.
- **branch_en in cycle B, no outstanding request** -> imem_addr=branch_target with imem_req=1 in B+1.

## Configuration
- **FETCH_REDIRECT_EN**
  - Defined: branch_en/branch_target behave as described above.
  - Undefined: both ports remain on the module but are ignored, and the redirect/discard logic is not generated.
  - Undefined builds are for straight-line programs ending in hlt.

## Test plan
- **Reset and short fetch.** rst for 2 cycles, RESET_PC=0x10, zero-wait memory returning 0x80123000 (add), instr_ready=1.
  - Expect imem_addr=0x10 the cycle after reset.
  - Expect instr_valid with opcode=0x80, rdest=1, rsrc1=2, rsrc2=3, imm=0x3000, instr_pc=0x10.
  - Expect the next request at 0x11.
- **Long form with wait states.** Word 0xA2500000 (cpyi) then 0xDEADBEEF, with imem_ack delayed 3 cycles per request.
  - Expect imem_req/addr held constant while waiting.
  - Expect imm=0xDEADBEEF, instr_pc=start address, and the next fetch at start+2.
- **Decode backpressure.** instr_ready=0 for 5 cycles.
  - Expect instr_valid and fields stable, and no imem_req.
  - Expect release on instr_ready=1, with a new request the next cycle.
- **Halt during an outstanding request.** Pulse halt while imem_req is high and imem_ack is delayed 2 cycles.
  - Expect imem_req held until ack, the data discarded, halted=1 the cycle after ack, and no further requests.
- **Redirect (FETCH_REDIRECT_EN).** branch_en with target 0x40 while in ISSUE.
  - Expect instr_valid to drop next cycle and imem_addr=0x40.
  - Repeat between the two words of a long-form instruction: the partial instruction is never issued.
  - Assert halt and branch_en together: expect HALTED.
- **PC wrap.** RESET_PC=2^ADDR_WIDTH-1, fetch a long-form instruction.
  - Expect the immediate fetched from address 0 and the next fetch from address 1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, fetches one- or two-word instructions over imem req/ack
// and issues them to decode over valid/ready. PC redirect is built only with FETCH_REDIRECT_EN.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            opcode,
  output logic [3:0]            rdest,
  output logic [3:0]            rsrc1,
  output logic [3:0]            rsrc2,
  output logic [31:0]           imm,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  halt,
  output logic                  halted,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target
);

  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH_WORD,
    FETCH_IMM,
    ISSUE,
    HALTED
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  req_q;
  logic                  halt_pend;
  logic                  long_form_c;
  logic                  halt_any_c;
  logic                  redir_c;
  logic [ADDR_WIDTH-1:0] redir_addr_c;

  // cpyi/stoa/loda carry a second word holding the immediate
  assign long_form_c = (imem_rdata[31:29] == 3'b101) || (imem_rdata[31:29] == 3'b110);
  assign halt_any_c  = halt || halt_pend;

`ifdef FETCH_REDIRECT_EN
  logic                  redir_pend;
  logic [ADDR_WIDTH-1:0] redir_tgt;

  assign redir_c      = !halt_any_c && (branch_en || redir_pend);
  assign redir_addr_c = branch_en ? branch_target : redir_tgt;

  // Remember a redirect seen while a request is in flight; a later one overwrites the target.
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else if ((state == FETCH_WORD || state == FETCH_IMM) && !imem_ack) begin
      if (branch_en && !halt_any_c) begin
        redir_pend <= 1'b1;
        redir_tgt  <= branch_target;
      end
    end else begin
      redir_pend <= 1'b0;
    end
  end
`else
  logic unused_redirect;

  assign unused_redirect = &{1'b0, branch_en, branch_target};
  assign redir_c         = 1'b0;
  assign redir_addr_c    = pc;
`endif

  // Reset drops the request in the same cycle; the slave tolerates an abandoned request then.
  assign imem_req  = req_q && !rst;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_WORD;
      pc          <= RESET_PC;
      req_q       <= 1'b1;
      halt_pend   <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      opcode      <= '0;
      rdest       <= '0;
      rsrc1       <= '0;
      rsrc2       <= '0;
      imm         <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        FETCH_WORD, FETCH_IMM: begin
          if (!imem_ack) begin
            if (halt) begin
              halt_pend <= 1'b1;
            end
          end else if (halt_any_c) begin
            halt_pend <= 1'b0;
            req_q     <= 1'b0;
            halted    <= 1'b1;
            state     <= HALTED;
          end else if (redir_c) begin
            pc    <= redir_addr_c;
            state <= FETCH_WORD;
          end else begin
            pc <= pc + ADDR_WIDTH'(1);
            if (state == FETCH_IMM) begin
              imm         <= imem_rdata;
              req_q       <= 1'b0;
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end else begin
              opcode   <= imem_rdata[31:24];
              rdest    <= imem_rdata[23:20];
              rsrc1    <= imem_rdata[19:16];
              rsrc2    <= imem_rdata[15:12];
              imm      <= WORD_WIDTH'(imem_rdata[15:0]);
              instr_pc <= pc;
              if (long_form_c) begin
                state <= FETCH_IMM;
              end else begin
                req_q       <= 1'b0;
                instr_valid <= 1'b1;
                state       <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          if (halt) begin
            instr_valid <= 1'b0;
            halted      <= 1'b1;
            state       <= HALTED;
          end else if (redir_c) begin
            pc          <= redir_addr_c;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= FETCH_WORD;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= FETCH_WORD;
          end
        end
        HALTED: begin
        end
        default: begin
          state <= FETCH_WORD;
        end
      endcase
    end
  end

endmodule
